// File: rtl/ise_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ise_seq_ctrl - central sequencer of the image sorting engine datapath.
//
// Counts incoming pixels per image and gates the pixel/strength accumulators.
// At the end of every image it launches the divider and commits the quotient
// to the sort register bank. After the last image of a set it starts the
// sorter, then streams the sorted results out with out_valid.
//
// Handshake semantics (one place, applies to every port below):
//   * A pixel is transferred in a cycle where in_valid=1 and busy=0 while the
//     sequencer is IDLE or ACCUM; acc_en reports exactly that transfer.
//   * busy is the only back-pressure; in_valid seen while busy=1 is ignored.
//   * div_done / sort_done are 1-cycle pulses, honoured only in DIV_WAIT /
//     SORT_WAIT and only when the matching start pulse is not on the wire.
//   * All outputs except acc_en are registered; all pulses are 1 cycle wide.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   in_valid       in   pixel / image_in_index valid this cycle
//   image_in_index in   [4:0] image the current pixel belongs to
//   div_done       in   divider result valid pulse
//   sort_done      in   sorter finished pulse
//   busy           out  registered back-pressure to the pixel source
//   acc_en         out  combinational, pixel accepted this cycle
//   acc_clr        out  pulse clearing the pixel/strength accumulators
//   div_start      out  pulse launching the divider
//   sr_wr_en       out  pulse writing the quotient into the sort bank
//   sr_wr_idx      out  [4:0] sort bank slot (index of image's first pixel)
//   sort_start     out  pulse launching the sorter
//   rd_addr        out  sorted-result read address
//   out_valid      out  sorted result present on the datapath outputs
//   state_dbg      out  [2:0] current FSM state (debug observation)
// ---------------------------------------------------------------------------
module ise_seq_ctrl #(
    parameter int PIX_PER_IMG = 4096,
    parameter int NUM_IMG     = 32,
    localparam int PIX_W      = (PIX_PER_IMG > 1) ? $clog2(PIX_PER_IMG) : 1,
    localparam int IMG_W      = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [4:0]       image_in_index,
    input  logic             div_done,
    input  logic             sort_done,
    output logic             busy,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             div_start,
    output logic             sr_wr_en,
    output logic [4:0]       sr_wr_idx,
    output logic             sort_start,
    output logic [IMG_W-1:0] rd_addr,
    output logic             out_valid,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCUM     = 3'd1,
        DIV_WAIT  = 3'd2,
        STORE     = 3'd3,
        SORT_WAIT = 3'd4,
        OUT       = 3'd5
    } state_t;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_IMG - 1);
    localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(NUM_IMG - 1);

    state_t             state_q,      state_d;
    logic [PIX_W-1:0]   pix_cnt_q,    pix_cnt_d;
    logic [IMG_W-1:0]   img_cnt_q,    img_cnt_d;
    logic [IMG_W-1:0]   rd_addr_q,    rd_addr_d;
    // High while rd_addr still points at an unread result; low for the one
    // drain cycle in OUT where the last result is being presented.
    logic               rd_active_q,  rd_active_d;
    logic               busy_q,       busy_d;
    logic               acc_clr_q,    acc_clr_d;
    logic               div_start_q,  div_start_d;
    logic               sr_wr_en_q,   sr_wr_en_d;
    logic [4:0]         sr_wr_idx_q,  sr_wr_idx_d;
    logic               sort_start_q, sort_start_d;
    logic               out_valid_q,  out_valid_d;
    logic               acc_en_c;

    assign acc_en_c = in_valid && !busy_q && (state_q == IDLE || state_q == ACCUM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            img_cnt_q    <= '0;
            rd_addr_q    <= '0;
            rd_active_q  <= 1'b0;
            busy_q       <= 1'b0;
            acc_clr_q    <= 1'b0;
            div_start_q  <= 1'b0;
            sr_wr_en_q   <= 1'b0;
            sr_wr_idx_q  <= '0;
            sort_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            img_cnt_q    <= img_cnt_d;
            rd_addr_q    <= rd_addr_d;
            rd_active_q  <= rd_active_d;
            busy_q       <= busy_d;
            acc_clr_q    <= acc_clr_d;
            div_start_q  <= div_start_d;
            sr_wr_en_q   <= sr_wr_en_d;
            sr_wr_idx_q  <= sr_wr_idx_d;
            sort_start_q <= sort_start_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        img_cnt_d    = img_cnt_q;
        rd_addr_d    = rd_addr_q;
        rd_active_d  = rd_active_q;
        busy_d       = busy_q;
        sr_wr_idx_d  = sr_wr_idx_q;
        acc_clr_d    = 1'b0;
        div_start_d  = 1'b0;
        sr_wr_en_d   = 1'b0;
        sort_start_d = 1'b0;
        out_valid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (acc_en_c) begin
                    // The image index is captured on the first pixel only.
                    sr_wr_idx_d = image_in_index;
                    if (PIX_PER_IMG == 1) begin
                        state_d     = DIV_WAIT;
                        busy_d      = 1'b1;
                        div_start_d = 1'b1;
                        pix_cnt_d   = '0;
                    end else begin
                        state_d   = ACCUM;
                        pix_cnt_d = PIX_W'(1);
                    end
                end
            end
            ACCUM: begin
                if (acc_en_c) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        state_d     = DIV_WAIT;
                        busy_d      = 1'b1;
                        div_start_d = 1'b1;
                        pix_cnt_d   = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    end
                end
            end
            DIV_WAIT: begin
                // A div_done landing on the div_start cycle belongs to an
                // earlier operation and is dropped.
                if (div_done && !div_start_q) begin
                    state_d    = STORE;
                    sr_wr_en_d = 1'b1;
                    acc_clr_d  = 1'b1;
                end
            end
            STORE: begin
                if (img_cnt_q == IMG_LAST) begin
                    state_d      = SORT_WAIT;
                    img_cnt_d    = '0;
                    sort_start_d = 1'b1;
                end else begin
                    state_d   = IDLE;
                    img_cnt_d = img_cnt_q + IMG_W'(1);
                    busy_d    = 1'b0;
                end
            end
            SORT_WAIT: begin
                if (sort_done && !sort_start_q) begin
                    state_d     = OUT;
                    rd_addr_d   = '0;
                    rd_active_d = 1'b1;
                end
            end
            OUT: begin
                // out_valid trails rd_addr by the one-cycle read latency, so
                // OUT lasts NUM_IMG address cycles plus one drain cycle.
                if (rd_active_q) begin
                    out_valid_d = 1'b1;
                    if (rd_addr_q == IMG_LAST) begin
                        rd_active_d = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q + IMG_W'(1);
                    end
                end else begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    rd_addr_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = busy_q;
    assign acc_en     = acc_en_c;
    assign acc_clr    = acc_clr_q;
    assign div_start  = div_start_q;
    assign sr_wr_en   = sr_wr_en_q;
    assign sr_wr_idx  = sr_wr_idx_q;
    assign sort_start = sort_start_q;
    assign rd_addr    = rd_addr_q;
    assign out_valid  = out_valid_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ise_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ise_seq_ctrl - self-checking bench for ise_seq_ctrl with
// PIX_PER_IMG=4 and NUM_IMG=4.
// ---------------------------------------------------------------------------
module tb_ise_seq_ctrl;

    localparam int PPI = 4;
    localparam int NIM = 4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACCUM     = 3'd1;
    localparam logic [2:0] S_DIV_WAIT  = 3'd2;
    localparam logic [2:0] S_STORE     = 3'd3;
    localparam logic [2:0] S_SORT_WAIT = 3'd4;
    localparam logic [2:0] S_OUT       = 3'd5;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] image_in_index = '0;
    logic       div_done = 1'b0;
    logic       sort_done = 1'b0;
    logic       busy, acc_en, acc_clr, div_start, sr_wr_en, sort_start, out_valid;
    logic [4:0] sr_wr_idx;
    logic [1:0] rd_addr;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    ise_seq_ctrl #(.PIX_PER_IMG(PPI), .NUM_IMG(NIM)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .image_in_index (image_in_index),
        .div_done       (div_done),
        .sort_done      (sort_done),
        .busy           (busy),
        .acc_en         (acc_en),
        .acc_clr        (acc_clr),
        .div_start      (div_start),
        .sr_wr_en       (sr_wr_en),
        .sr_wr_idx      (sr_wr_idx),
        .sort_start     (sort_start),
        .rd_addr        (rd_addr),
        .out_valid      (out_valid),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cnt_sort_start = 0;
    int cnt_out_valid  = 0;
    logic [4:0] exp_q[$];
    logic [1:0] out_q[$];
    logic [1:0] rd_prev = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pops the expected slot on every sort bank write and the expected read
    // address on every out_valid cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (sr_wr_en) begin
                if (exp_q.size() == 0) chk("sr_wr_unexpected", 1, 0);
                else chk("sr_wr_idx", 32'(sr_wr_idx), 32'(exp_q.pop_front()));
            end
            if (sr_wr_en || acc_clr) chk("acc_clr_with_sr_wr", 32'(acc_clr), 32'(sr_wr_en));
            if (out_valid) begin
                cnt_out_valid++;
                if (out_q.size() == 0) chk("out_valid_unexpected", 1, 0);
                else chk("rd_addr_before_out_valid", 32'(rd_prev), 32'(out_q.pop_front()));
            end
            if (sort_start) cnt_sort_start++;
        end
        rd_prev = rd_addr;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},       32'(busy), 0);
        chk({tag, "_acc_en"},     32'(acc_en), 0);
        chk({tag, "_acc_clr"},    32'(acc_clr), 0);
        chk({tag, "_div_start"},  32'(div_start), 0);
        chk({tag, "_sr_wr_en"},   32'(sr_wr_en), 0);
        chk({tag, "_sr_wr_idx"},  32'(sr_wr_idx), 0);
        chk({tag, "_sort_start"}, 32'(sort_start), 0);
        chk({tag, "_rd_addr"},    32'(rd_addr), 0);
        chk({tag, "_out_valid"},  32'(out_valid), 0);
        chk({tag, "_state"},      32'(state_dbg), 32'(S_IDLE));
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic reset_mid(input string tag);
        in_valid = 1'b0; div_done = 1'b0; sort_done = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        out_q.delete();
        step();
    endtask

    // Drives one image back to back; ends in cycle T+1 (div_start visible).
    task automatic drive_pixels(input logic [4:0] idx, input bit hold, input bit spur);
        for (int k = 0; k < PPI; k++) begin
            in_valid = 1'b1;
            image_in_index = (k == 0) ? idx : 5'($urandom_range(0, 31));
            div_done = spur && (k == 1);
            if (k == 0) exp_q.push_back(idx);
            #1;
            chk("pix_acc_en", 32'(acc_en), 1);
            chk("pix_busy", 32'(busy), 0);
            chk("pix_state", 32'(state_dbg), (k == 0) ? 32'(S_IDLE) : 32'(S_ACCUM));
            step();
        end
        in_valid = hold;
        div_done = spur;
        #1;
        chk("t1_div_start", 32'(div_start), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_acc_en", 32'(acc_en), 0);
        chk("t1_state", 32'(state_dbg), 32'(S_DIV_WAIT));
    endtask

    // From T+1: waits, pulses div_done, checks the store and release cycles.
    task automatic finish_div(input int waits, input bit hold, input bit final_img);
        for (int w = 0; w < waits; w++) begin
            div_done = 1'b0;
            step();
            chk("dw_div_start", 32'(div_start), 0);
            chk("dw_busy", 32'(busy), 1);
            chk("dw_acc_en", 32'(acc_en), 0);
            chk("dw_state", 32'(state_dbg), 32'(S_DIV_WAIT));
        end
        div_done = 1'b1;
        step();
        div_done = 1'b0;
        #1;
        chk("st_sr_wr_en", 32'(sr_wr_en), 1);
        chk("st_acc_clr", 32'(acc_clr), 1);
        chk("st_busy", 32'(busy), 1);
        chk("st_acc_en", 32'(acc_en), 0);
        chk("st_state", 32'(state_dbg), 32'(S_STORE));
        step();
        chk("rel_sr_wr_en", 32'(sr_wr_en), 0);
        if (final_img) begin
            chk("rel_sort_start", 32'(sort_start), 1);
            chk("rel_busy_final", 32'(busy), 1);
            chk("rel_acc_en_final", 32'(acc_en), 0);
            chk("rel_state_final", 32'(state_dbg), 32'(S_SORT_WAIT));
        end else begin
            chk("rel_busy", 32'(busy), 0);
            chk("rel_acc_en", 32'(acc_en), 32'(hold));
            chk("rel_state", 32'(state_dbg), 32'(S_IDLE));
        end
    endtask

    // From the sort_start cycle: sorter handshake and the full output stream.
    task automatic do_sort(input int waits, input bit spur);
        sort_done = spur;
        step();
        sort_done = 1'b0;
        chk("sw_sort_start", 32'(sort_start), 0);
        chk("sw_state", 32'(state_dbg), 32'(S_SORT_WAIT));
        for (int w = 0; w < waits; w++) begin
            step();
            chk("sw_state_wait", 32'(state_dbg), 32'(S_SORT_WAIT));
        end
        sort_done = 1'b1;
        for (int i = 0; i < NIM; i++) out_q.push_back(2'(i));
        step();
        sort_done = 1'b0;
        chk("out_state", 32'(state_dbg), 32'(S_OUT));
        chk("out_rd_addr0", 32'(rd_addr), 0);
        chk("out_valid_s1", 32'(out_valid), 0);
        for (int i = 0; i < NIM; i++) begin
            sort_done = spur && (i == 1);
            div_done  = spur && (i == 1);
            step();
            chk("out_valid", 32'(out_valid), 1);
            chk("out_busy", 32'(busy), 1);
            chk("out_state_stream", 32'(state_dbg), 32'(S_OUT));
            if (i < NIM - 1) chk("out_rd_addr", 32'(rd_addr), 32'(i + 1));
        end
        sort_done = 1'b0;
        div_done  = 1'b0;
        step();
        chk("end_out_valid", 32'(out_valid), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_state", 32'(state_dbg), 32'(S_IDLE));
        chk("end_rd_addr", 32'(rd_addr), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       iv;
        logic [4:0] idx;
        logic       dd;
        logic       sd;
        logic       push;
        logic       busy, acc_en, acc_clr, div_start, sr_wr_en, sort_start, out_valid;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[10];

    task automatic set_row(input int i, input logic iv, input logic [4:0] idx,
                           input logic dd, input logic sd, input logic push,
                           input logic b, input logic ae, input logic ac,
                           input logic ds, input logic we, input logic [2:0] st);
        tbl[i].iv = iv; tbl[i].idx = idx; tbl[i].dd = dd; tbl[i].sd = sd;
        tbl[i].push = push; tbl[i].busy = b; tbl[i].acc_en = ae;
        tbl[i].acc_clr = ac; tbl[i].div_start = ds; tbl[i].sr_wr_en = we;
        tbl[i].sort_start = 1'b0; tbl[i].out_valid = 1'b0; tbl[i].st = st;
    endtask

    // ---------------- test sequence ----------------
    int ss0, ov0;

    initial begin
        // Single image, last pixel at row 3 (T); coincident div_done at T+1,
        // spurious div_done in ACCUM and sort_done in DIV_WAIT; div_done at T+4.
        //          row iv idx    dd sd push busy acc clr ds we  state
        set_row(0, 1, 5'd5, 0, 0, 1,   0,   1,  0,  0, 0, S_IDLE);
        set_row(1, 1, 5'd9, 1, 0, 0,   0,   1,  0,  0, 0, S_ACCUM);
        set_row(2, 1, 5'd9, 0, 0, 0,   0,   1,  0,  0, 0, S_ACCUM);
        set_row(3, 1, 5'd9, 0, 0, 0,   0,   1,  0,  0, 0, S_ACCUM);
        set_row(4, 1, 5'd9, 1, 0, 0,   1,   0,  0,  1, 0, S_DIV_WAIT);
        set_row(5, 1, 5'd9, 0, 1, 0,   1,   0,  0,  0, 0, S_DIV_WAIT);
        set_row(6, 0, 5'd0, 0, 0, 0,   1,   0,  0,  0, 0, S_DIV_WAIT);
        set_row(7, 0, 5'd0, 1, 0, 0,   1,   0,  0,  0, 0, S_DIV_WAIT);
        set_row(8, 0, 5'd0, 0, 0, 0,   1,   0,  1,  0, 1, S_STORE);
        set_row(9, 0, 5'd0, 0, 0, 0,   0,   0,  0,  0, 0, S_IDLE);

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid       = 1'($urandom_range(0, 1));
            image_in_index = 5'($urandom_range(0, 31));
            div_done       = 1'($urandom_range(0, 1));
            sort_done      = 1'($urandom_range(0, 1));
            if (i == 3) chk("in_reset_busy", 32'(busy), 0);
        end
        in_valid = 1'b0; div_done = 1'b0; sort_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        chk_all_zero("post_reset");

        // Table-driven single image.
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].iv;
            image_in_index = tbl[i].idx;
            div_done = tbl[i].dd;
            sort_done = tbl[i].sd;
            if (tbl[i].push) exp_q.push_back(tbl[i].idx);
            #1;
            chk($sformatf("row%0d_busy", i),       32'(busy),       32'(tbl[i].busy));
            chk($sformatf("row%0d_acc_en", i),     32'(acc_en),     32'(tbl[i].acc_en));
            chk($sformatf("row%0d_acc_clr", i),    32'(acc_clr),    32'(tbl[i].acc_clr));
            chk($sformatf("row%0d_div_start", i),  32'(div_start),  32'(tbl[i].div_start));
            chk($sformatf("row%0d_sr_wr_en", i),   32'(sr_wr_en),   32'(tbl[i].sr_wr_en));
            chk($sformatf("row%0d_sort_start", i), 32'(sort_start), 32'(tbl[i].sort_start));
            chk($sformatf("row%0d_out_valid", i),  32'(out_valid),  32'(tbl[i].out_valid));
            chk($sformatf("row%0d_state", i),      32'(state_dbg),  32'(tbl[i].st));
            step();
        end

        // Back-pressure: in_valid held through a long DIV_WAIT; the next image
        // starts the cycle busy falls and needs exactly PPI accepted pixels.
        drive_pixels(5'd7, 1'b1, 1'b0);
        finish_div(10, 1'b1, 1'b0);
        drive_pixels(5'd12, 1'b1, 1'b0);
        step();
        chk("dw_hold_state", 32'(state_dbg), 32'(S_DIV_WAIT));
        reset_mid("rst_div_wait");

        // Full run of four images, indices 3,0,2,1, with spurious handshakes.
        ss0 = cnt_sort_start;
        ov0 = cnt_out_valid;
        drive_pixels(5'd3, 1'b0, 1'b1); finish_div(3, 1'b0, 1'b0);
        drive_pixels(5'd0, 1'b0, 1'b0); finish_div(2, 1'b0, 1'b0);
        drive_pixels(5'd2, 1'b0, 1'b1); finish_div(5, 1'b0, 1'b0);
        drive_pixels(5'd1, 1'b0, 1'b0); finish_div(1, 1'b0, 1'b1);
        do_sort(2, 1'b1);
        chk("run_sort_start_count", 32'(cnt_sort_start - ss0), 1);
        chk("run_out_valid_count", 32'(cnt_out_valid - ov0), 32'(NIM));
        chk("run_exp_q_empty", 32'(exp_q.size()), 0);
        chk("run_out_q_empty", 32'(out_q.size()), 0);

        // Second run, reset while streaming at rd_addr=2.
        for (int n = 0; n < NIM; n++) begin
            drive_pixels(5'($urandom_range(0, 31)), 1'b0, 1'b0);
            finish_div($urandom_range(1, 4), 1'b0, (n == NIM - 1));
        end
        step();
        sort_done = 1'b1;
        for (int i = 0; i < NIM; i++) out_q.push_back(2'(i));
        step();
        sort_done = 1'b0;
        step();
        step();
        chk("pre_rst_rd_addr", 32'(rd_addr), 2);
        chk("pre_rst_out_valid", 32'(out_valid), 1);
        reset_mid("rst_out");

        // Fresh single image after the mid-operation resets.
        drive_pixels(5'd5, 1'b0, 1'b0);
        finish_div(3, 1'b0, 1'b0);
        step();
        chk("final_exp_q_empty", 32'(exp_q.size()), 0);
        chk("final_state", 32'(state_dbg), 32'(S_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
